counter_rr_scheduler: RTL
=========================

// Module: counter_rr_scheduler
// PURPOSE
// - Shares one CW-bit down-counter (interval timer) among NREQ requesters.
// - Round-robin arbiter picks one requester, loads its interval length and counts it down.
//   Signals completion to that requester only.
// - Sits between requester blocks and the shared counter resource; owns counter sequencing.
// PARAMETERS
// - NREQ  4  number of requesters (>=2)
// - CW    8  counter / interval-length width in bits
// PORTS
// - clk       in   1        system clock; all state updates on rising edge
// - rst       in   1        reset, asynchronous, active-high
// - req       in   NREQ     per-requester request level; held until done[i] or abort
// - req_len   in   NREQ*CW  interval length; requester i uses bits [i*CW +: CW]
// - gnt       out  NREQ     one-hot grant; high while owner's interval runs
// - count     out  CW       current counter value; 0 when idle
// - busy      out  1        1 when state != IDLE
// - done      out  NREQ     one-cycle one-hot completion pulse to owner
// BEHAVIOUR
// - One clock; reset is asynchronous and active-high.
// - Reset, including mid-operation, applies immediately without waiting for clk:
//   state=IDLE, gnt=0, count=0, done=0, busy=0, ptr=0, owner=0.
// - FSM states and transitions:
//   - IDLE: if |req, take the first set req[i] scanning ptr, ptr+1, ... modulo NREQ.
//     At the edge: state<=RUN, gnt<=onehot(i), owner<=i, count<=req_len[i].
//     If req==0, stay in IDLE.
//   - RUN, count!=0: count<=count-1.
//   - RUN, count==0: state<=DONE, gnt<=0, done<=onehot(owner).
//   - DONE: done<=0, ptr<=(owner+1) mod NREQ, state<=IDLE.
// - Latency:
//   - gnt rises 1 cycle after req is sampled in IDLE.
//   - gnt stays high for len+1 cycles; len=0 gives a 1-cycle grant and is legal.
//   - done pulses in the cycle after gnt falls.
//   - The next grant is possible 2 cycles after gnt falls (DONE, then IDLE arbitration).
// - req_len is sampled only at grant; later changes have no effect on the running interval.
// - Arbitration is fair: a requester holding req waits at most NREQ-1 intervals.
// - Simultaneous requests: the lowest index at or after ptr wins.
//   ptr advances only on completion; with the abort option, also on abort.
// - A requester whose req is still high in IDLE after its own done is eligible again.
//   It has the lowest priority because ptr has moved past it.
// - count is 0 in IDLE and in DONE. In RUN it equals the remaining cycles.
// - The down-counter never wraps: the decrement is gated at 0.
// - req changes during RUN never alter gnt or owner, except when the abort option is built.
// CONFIGURATION
// - COUNTER_SCHED_ABORT_EN defined:
//   - In RUN, if req[owner]==0: next edge sets gnt<=0, count<=0, state<=IDLE, ptr<=(owner+1) mod NREQ.
//   - No done pulse is issued.
//   - If the abort and the count==0 completion occur in the same cycle, the abort wins.
// - COUNTER_SCHED_ABORT_EN undefined:
//   - A req drop during RUN is ignored; the interval completes and done still pulses.
// TESTING  (NREQ=4, CW=8)
// - Reset, idle: rst=1 then 0 with req=0.
//   -> gnt=0, count=0, busy=0, done=0 for 10 cycles.
// - Single request: req=4'b0010, len1=3.
//   -> gnt=0010 for exactly 4 cycles with count 3,2,1,0.
//   -> done=0010 for 1 cycle; busy falls 1 cycle later.
// - Round-robin: req=4'b1111 held, all len=1.
//   -> grant order 0,1,2,3,0.
//   -> each gnt 2 cycles; 2-cycle gap between grants.
// - Zero length and sample-at-grant: len2=0, then len2 changed to 9 while gnt is high.
//   -> gnt=0100 for 1 cycle, count=0, done pulse follows.
// - Reset mid-RUN: len0=20; assert rst at count=12, asynchronous to clk.
//   -> all outputs 0 immediately; after release, req=0001 gets a fresh count of 20.
// - Abort: len3=10; drop req3 at count=5.
//   -> ABORT_EN defined: gnt=0 next cycle, no done, next arbitration starts at index 0.
//   -> ABORT_EN undefined: counts to 0 and done=1000.

Source files
------------

// File: rtl/counter_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_rr_scheduler_if
// Purpose  : Requester <-> scheduler bundle for the shared interval counter.
//            master = requester side, slave = scheduler side.
// Revision : 1.0 - initial release
// ============================================================================
interface counter_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int CW   = 8
);
  logic [NREQ-1:0]    req;      // per-requester request level
  logic [NREQ*CW-1:0] req_len;  // requester i uses bits [i*CW +: CW]
  logic [NREQ-1:0]    gnt;      // one-hot grant while the interval runs
  logic [CW-1:0]      count;    // remaining cycles, 0 when idle
  logic               busy;     // scheduler not idle
  logic [NREQ-1:0]    done;     // one-cycle completion pulse to the owner

  modport master (
    output req, req_len,
    input  gnt, count, busy, done
  );

  modport slave (
    input  req, req_len,
    output gnt, count, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/counter_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : counter_rr_scheduler
// Purpose  : Shares one CW-bit down-counter among NREQ requesters. A
//            round-robin arbiter picks a requester, loads its interval length,
//            counts it down to 0 and pulses done to that requester only.
// Options  : COUNTER_SCHED_ABORT_EN - owner dropping req during RUN aborts the
//            interval (no done pulse, pointer advances past the owner).
// Revision : 1.0 - initial release
// ============================================================================
module counter_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  counter_rr_scheduler_if.slave   bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   count_q, count_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;

  logic [CW-1:0]   len_arr [NREQ];
  logic [PW:0]     scan_idx;
  logic [PW-1:0]   win_idx;
  logic            win_found;
  logic [PW-1:0]   owner_nxt;
  logic            abort;

  // Unpack the flat length bus so it can be indexed by the winner
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
      assign len_arr[gi] = bus.req_len[gi*CW +: CW];
    end
  endgenerate

  // Round-robin scan: first set req at ptr, ptr+1, ... modulo NREQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (scan_idx >= (PW+1)'(NREQ)) begin
        scan_idx = scan_idx - (PW+1)'(NREQ);
      end
      if (!win_found && bus.req[scan_idx[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[PW-1:0];
      end
    end
  end

  // Pointer value that places the current owner at lowest priority
  always_comb begin
    owner_nxt = (owner_q == PW'(NREQ-1)) ? '0 : owner_q + PW'(1);
  end

  // Abort request from the owner; tied off when the option is not built
  always_comb begin
`ifdef COUNTER_SCHED_ABORT_EN
    abort = !bus.req[owner_q];
`else
    abort = 1'b0;
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    count_d = count_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_RUN;
          gnt_d   = NREQ'(1) << win_idx;
          owner_d = win_idx;
          count_d = len_arr[win_idx];
        end
      end
      S_RUN: begin
        if (abort) begin
          // Abort beats a same-cycle completion: no done pulse
          state_d = S_IDLE;
          gnt_d   = '0;
          count_d = '0;
          ptr_d   = owner_nxt;
        end else if (count_q != '0) begin
          count_d = count_q - CW'(1);
        end else begin
          state_d = S_DONE;
          gnt_d   = '0;
          done_d  = NREQ'(1) << owner_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = owner_nxt;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        count_d = '0;
      end
    endcase
  end

  // State register; reset takes effect immediately, independent of clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      count_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      count_q <= count_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.count = count_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = done_q;

endmodule
`default_nettype wire
